// File: rtl/serial_width_converter.sv
// serial_width_converter
// Converts a put/free handshaked stream between INPUT_WIDTH and OUTPUT_WIDTH.
// Three build shapes are selected from the parameters:
//   - equal widths : one-entry register stage
//   - wide->narrow : holding register emitted slice by slice (EMPTY/BUSY FSM)
//   - narrow->wide : accumulator with partial flush on data_in_last
// Packet framing travels on the *_last flags, and data_out_count reports how
// many NARROW-wide slices of data_out are valid.
// Optional macro SERIAL_WIDTH_CONVERTER_MSB_FIRST_EN reverses slice ordering
// (most-significant slice first); handshakes, latency and counts are unchanged.
module serial_width_converter #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    data_in_put,
  output logic                    data_in_free,
  input  logic [INPUT_WIDTH-1:0]  data_in,
  input  logic                    data_in_last,
  output logic                    data_out_put,
  input  logic                    data_out_free,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic                    data_out_last,
  output logic [7:0]              data_out_count
);

  localparam int NARROW = (INPUT_WIDTH < OUTPUT_WIDTH) ? INPUT_WIDTH : OUTPUT_WIDTH;
  localparam int WIDE   = (INPUT_WIDTH < OUTPUT_WIDTH) ? OUTPUT_WIDTH : INPUT_WIDTH;
  localparam int RATIO  = (NARROW >= 1) ? (WIDE / NARROW) : 1;

  generate
    if (NARROW < 1 || (WIDE % ((NARROW >= 1) ? NARROW : 1)) != 0 || RATIO > 255) begin : g_bad_config
      $error("serial_width_converter: widths must be >=1, exact multiples, ratio <= 255");
      assign data_in_free   = 1'b0;
      assign data_out_put   = 1'b0;
      assign data_out       = '0;
      assign data_out_last  = 1'b0;
      assign data_out_count = 8'd0;

    end else if (INPUT_WIDTH == OUTPUT_WIDTH) begin : g_equal
      // A word may enter whenever the stage is empty or is being drained this cycle.
      assign data_in_free = !data_out_put | data_out_free;

      // Single register stage: capture on every accepted word, drop valid when drained.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_out_put   <= 1'b0;
          data_out       <= '0;
          data_out_last  <= 1'b0;
          data_out_count <= 8'd0;
        end else if (data_in_free) begin
          data_out_put <= data_in_put;
          if (data_in_put) begin
            data_out       <= data_in;
            data_out_last  <= data_in_last;
            data_out_count <= 8'd1;
          end
        end
      end

    end else if (INPUT_WIDTH > OUTPUT_WIDTH) begin : g_serialise
`ifdef SERIAL_WIDTH_CONVERTER_MSB_FIRST_EN
      localparam bit MSB_FIRST = 1'b1;
`else
      localparam bit MSB_FIRST = 1'b0;
`endif
      localparam logic [7:0] RATIO_M1 = 8'(RATIO - 1);

      typedef enum logic {EMPTY, BUSY} state_t;

      state_t                 state;
      logic [INPUT_WIDTH-1:0] hold;
      logic [7:0]             idx;
      logic                   last_q;
      logic                   in_xfer;
      logic                   out_xfer;

      // Picks the i-th emitted slice of a word, honouring the slice ordering.
      function automatic logic [NARROW-1:0] slice_of(input logic [INPUT_WIDTH-1:0] w,
                                                     input logic [7:0] i);
        int p;
        p = MSB_FIRST ? (RATIO - 1 - int'(i)) : int'(i);
        return w[p*NARROW +: NARROW];
      endfunction

      // A new word is taken only when empty, or as the final slice leaves (no bubble).
      assign data_in_free = (state == EMPTY) | ((idx == RATIO_M1) & data_out_free);
      assign in_xfer      = data_in_put & data_in_free;
      assign out_xfer     = data_out_put & data_out_free;

      // Serialiser FSM; the presented slice and its last flag are kept registered.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state          <= EMPTY;
          hold           <= '0;
          idx            <= 8'd0;
          last_q         <= 1'b0;
          data_out_put   <= 1'b0;
          data_out       <= '0;
          data_out_last  <= 1'b0;
          data_out_count <= 8'd0;
        end else begin
          case (state)
            EMPTY: begin
              if (in_xfer) begin
                state          <= BUSY;
                hold           <= data_in;
                last_q         <= data_in_last;
                idx            <= 8'd0;
                data_out_put   <= 1'b1;
                data_out       <= slice_of(data_in, 8'd0);
                data_out_last  <= 1'b0;
                data_out_count <= 8'd1;
              end
            end
            BUSY: begin
              if (in_xfer) begin
                hold           <= data_in;
                last_q         <= data_in_last;
                idx            <= 8'd0;
                data_out_put   <= 1'b1;
                data_out       <= slice_of(data_in, 8'd0);
                data_out_last  <= 1'b0;
                data_out_count <= 8'd1;
              end else if (out_xfer) begin
                if (idx == RATIO_M1) begin
                  state         <= EMPTY;
                  data_out_put  <= 1'b0;
                  data_out_last <= 1'b0;
                end else begin
                  idx           <= idx + 8'd1;
                  data_out      <= slice_of(hold, idx + 8'd1);
                  data_out_last <= last_q & ((idx + 8'd1) == RATIO_M1);
                end
              end
            end
            default: state <= EMPTY;
          endcase
        end
      end

    end else begin : g_deserialise
`ifdef SERIAL_WIDTH_CONVERTER_MSB_FIRST_EN
      localparam bit MSB_FIRST = 1'b1;
`else
      localparam bit MSB_FIRST = 1'b0;
`endif
      localparam logic [7:0] RATIO_M1 = 8'(RATIO - 1);

      logic [OUTPUT_WIDTH-1:0] acc;
      logic [OUTPUT_WIDTH-1:0] next_acc;
      logic [7:0]              fill;
      logic                    completing_cand;
      logic                    completing;
      logic                    in_xfer;
      logic                    out_xfer;
      int                      pos;

      // Accumulator image with the offered slice merged in at the current fill position.
      always_comb begin
        pos      = MSB_FIRST ? (RATIO - 1 - int'(fill)) : int'(fill);
        next_acc = acc;
        next_acc[pos*NARROW +: NARROW] = data_in;
      end

      // Only a word-completing slice can be blocked, and only by an undrained output.
      assign completing_cand = data_in_put & ((fill == RATIO_M1) | data_in_last);
      assign data_in_free    = !(completing_cand & data_out_put & !data_out_free);
      assign in_xfer         = data_in_put & data_in_free;
      assign completing      = completing_cand & data_in_free;
      assign out_xfer        = data_out_put & data_out_free;

      // Fill the accumulator and hand completed (or flushed) words to the output register.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          acc            <= '0;
          fill           <= 8'd0;
          data_out_put   <= 1'b0;
          data_out       <= '0;
          data_out_last  <= 1'b0;
          data_out_count <= 8'd0;
        end else begin
          if (out_xfer) begin
            data_out_put <= 1'b0;
          end
          if (completing) begin
            data_out       <= next_acc;
            data_out_count <= fill + 8'd1;
            data_out_last  <= data_in_last;
            data_out_put   <= 1'b1;
            acc            <= '0;
            fill           <= 8'd0;
          end else if (in_xfer) begin
            acc  <= next_acc;
            fill <= fill + 8'd1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_serial_width_converter.sv
// tb_serial_width_converter
// Directed bench driving five converter shapes (8->1, 1->8, 8->32, 16->16,
// 32->8) from one linear initial block with hand-computed expectations.
// Expected slice ordering follows SERIAL_WIDTH_CONVERTER_MSB_FIRST_EN.
module tb_serial_width_converter;

`ifdef SERIAL_WIDTH_CONVERTER_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  // 8 -> 1
  logic a_ip, a_if, a_il, a_op, a_of, a_ol;
  logic [7:0] a_din;
  logic [0:0] a_dout;
  logic [7:0] a_cnt;
  // 1 -> 8
  logic b_ip, b_if, b_il, b_op, b_of, b_ol;
  logic [0:0] b_din;
  logic [7:0] b_dout;
  logic [7:0] b_cnt;
  // 8 -> 32
  logic c_ip, c_if, c_il, c_op, c_of, c_ol;
  logic [7:0]  c_din;
  logic [31:0] c_dout;
  logic [7:0]  c_cnt;
  // 16 -> 16
  logic d_ip, d_if, d_il, d_op, d_of, d_ol;
  logic [15:0] d_din;
  logic [15:0] d_dout;
  logic [7:0]  d_cnt;
  // 32 -> 8
  logic e_ip, e_if, e_il, e_op, e_of, e_ol;
  logic [31:0] e_din;
  logic [7:0]  e_dout;
  logic [7:0]  e_cnt;

  serial_width_converter #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(1)) u_a (
    .clk(clk), .reset(reset), .data_in_put(a_ip), .data_in_free(a_if), .data_in(a_din),
    .data_in_last(a_il), .data_out_put(a_op), .data_out_free(a_of), .data_out(a_dout),
    .data_out_last(a_ol), .data_out_count(a_cnt));
  serial_width_converter #(.INPUT_WIDTH(1), .OUTPUT_WIDTH(8)) u_b (
    .clk(clk), .reset(reset), .data_in_put(b_ip), .data_in_free(b_if), .data_in(b_din),
    .data_in_last(b_il), .data_out_put(b_op), .data_out_free(b_of), .data_out(b_dout),
    .data_out_last(b_ol), .data_out_count(b_cnt));
  serial_width_converter #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(32)) u_c (
    .clk(clk), .reset(reset), .data_in_put(c_ip), .data_in_free(c_if), .data_in(c_din),
    .data_in_last(c_il), .data_out_put(c_op), .data_out_free(c_of), .data_out(c_dout),
    .data_out_last(c_ol), .data_out_count(c_cnt));
  serial_width_converter #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(16)) u_d (
    .clk(clk), .reset(reset), .data_in_put(d_ip), .data_in_free(d_if), .data_in(d_din),
    .data_in_last(d_il), .data_out_put(d_op), .data_out_free(d_of), .data_out(d_dout),
    .data_out_last(d_ol), .data_out_count(d_cnt));
  serial_width_converter #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(8)) u_e (
    .clk(clk), .reset(reset), .data_in_put(e_ip), .data_in_free(e_if), .data_in(e_din),
    .data_in_last(e_il), .data_out_put(e_op), .data_out_free(e_of), .data_out(e_dout),
    .data_out_last(e_ol), .data_out_count(e_cnt));

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Linear directed sequence covering every converter shape.
  initial begin
    logic [7:0]  word8;
    logic [7:0]  bits1;
    logic [2:0]  bits2;
    logic [31:0] beef;
    logic [31:0] w1, w2, wp;
    logic [16:0] q[$];
    logic [16:0] front;
    logic [16:0] prev_word;
    logic        exp_bit;
    logic        holding, prev_in, in_x, out_x;
    int          sent, recv, cyc, ones;

    {a_ip, a_il, a_of, a_din} = '0;
    {b_ip, b_il, b_of, b_din} = '0;
    {c_ip, c_il, c_of, c_din} = '0;
    {d_ip, d_il, d_of, d_din} = '0;
    {e_ip, e_il, e_of, e_din} = '0;
    reset = 1'b0;
    repeat (3) step_cycle();

    // Reset state
    check_output("rst_a_put",   64'(a_op),  64'd0);
    check_output("rst_a_data",  64'(a_dout), 64'd0);
    check_output("rst_a_last",  64'(a_ol),  64'd0);
    check_output("rst_a_count", 64'(a_cnt), 64'd0);
    check_output("rst_a_free",  64'(a_if),  64'd1);
    check_output("rst_b_put",   64'(b_op),  64'd0);
    check_output("rst_b_free",  64'(b_if),  64'd1);
    check_output("rst_c_data",  64'(c_dout), 64'd0);
    check_output("rst_d_put",   64'(d_op),  64'd0);
    check_output("rst_d_free",  64'(d_if),  64'd1);
    check_output("rst_e_count", 64'(e_cnt), 64'd0);
    reset = 1'b1;
    step_cycle();

    // 8->1: 0xA5 then 0x3C (last), sink always free
    a_of = 1'b1; a_din = 8'hA5; a_il = 1'b0; a_ip = 1'b1;
    #1;
    check_output("w2n_free_empty", 64'(a_if), 64'd1);
    step_cycle();
    a_din = 8'h3C; a_il = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      word8   = (k < 8) ? 8'hA5 : 8'h3C;
      exp_bit = MSB ? word8[7 - (k % 8)] : word8[k % 8];
      check_output($sformatf("w2n_put_%0d", k),  64'(a_op),   64'd1);
      check_output($sformatf("w2n_bit_%0d", k),  64'(a_dout), 64'(exp_bit));
      check_output($sformatf("w2n_last_%0d", k), 64'(a_ol),   64'(k == 15));
      check_output($sformatf("w2n_free_%0d", k), 64'(a_if),   64'((k == 7) || (k == 15)));
      step_cycle();
      if (k == 7) begin
        a_ip = 1'b0; a_il = 1'b0;
      end
    end
    #1;
    check_output("w2n_idle", 64'(a_op), 64'd0);

    // 1->8: full word then a 3-slice flushed packet
    bits1 = 8'b0000_1011;
    bits2 = 3'b101;
    b_of = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_ip = 1'b1; b_din = bits1[i]; b_il = 1'b0;
      #1;
      check_output($sformatf("n2w_free_%0d", i), 64'(b_if), 64'd1);
      step_cycle();
    end
    b_ip = 1'b0;
    #1;
    check_output("n2w_put",   64'(b_op),   64'd1);
    check_output("n2w_word",  64'(b_dout), MSB ? 64'hD0 : 64'h0B);
    check_output("n2w_count", 64'(b_cnt),  64'd8);
    check_output("n2w_last",  64'(b_ol),   64'd0);
    step_cycle();
    #1;
    check_output("n2w_drained", 64'(b_op), 64'd0);
    for (int i = 0; i < 3; i++) begin
      b_ip = 1'b1; b_din = bits2[i]; b_il = (i == 2);
      step_cycle();
    end
    b_ip = 1'b0; b_il = 1'b0;
    #1;
    check_output("n2w_part_put",   64'(b_op),   64'd1);
    check_output("n2w_part_word",  64'(b_dout), MSB ? 64'hA0 : 64'h05);
    check_output("n2w_part_count", 64'(b_cnt),  64'd3);
    check_output("n2w_part_last",  64'(b_ol),   64'd1);
    step_cycle();
    #1;
    check_output("n2w_part_drained", 64'(b_op), 64'd0);

    // 8->32: sink blocked while 0x11..0x18 are offered
    w1 = MSB ? 32'h11121314 : 32'h14131211;
    w2 = MSB ? 32'h15161718 : 32'h18171615;
    c_of = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c_ip = 1'b1; c_din = 8'h11 + 8'(i); c_il = 1'b0;
      #1;
      check_output($sformatf("n2w32_free_%0d", i), 64'(c_if), 64'(i != 7));
      if (i >= 4) begin
        check_output($sformatf("n2w32_hold_put_%0d", i),  64'(c_op),   64'd1);
        check_output($sformatf("n2w32_hold_data_%0d", i), 64'(c_dout), 64'(w1));
      end
      if (i < 7) step_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      step_cycle();
      #1;
      check_output("n2w32_stall_data", 64'(c_dout), 64'(w1));
      check_output("n2w32_stall_free", 64'(c_if),   64'd0);
    end
    c_of = 1'b1;
    #1;
    check_output("n2w32_release_free", 64'(c_if), 64'd1);
    step_cycle();
    c_ip = 1'b0;
    #1;
    check_output("n2w32_second_put",   64'(c_op),   64'd1);
    check_output("n2w32_second_data",  64'(c_dout), 64'(w2));
    check_output("n2w32_second_count", 64'(c_cnt),  64'd4);
    step_cycle();
    #1;
    check_output("n2w32_drained", 64'(c_op), 64'd0);
    c_ip = 1'b1; c_din = 8'hAA; c_il = 1'b0;
    step_cycle();
    c_din = 8'hBB; c_il = 1'b1;
    step_cycle();
    c_ip = 1'b0; c_il = 1'b0;
    wp = MSB ? 32'hAABB0000 : 32'h0000BBAA;
    #1;
    check_output("n2w32_part_data",  64'(c_dout), 64'(wp));
    check_output("n2w32_part_count", 64'(c_cnt),  64'd2);
    check_output("n2w32_part_last",  64'(c_ol),   64'd1);
    step_cycle();
    #1;
    check_output("n2w32_part_drained", 64'(c_op), 64'd0);

    // 32->8: 0xDEADBEEF
    beef = 32'hDEADBEEF;
    e_of = 1'b1; e_ip = 1'b1; e_din = beef; e_il = 1'b1;
    step_cycle();
    e_ip = 1'b0; e_il = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      word8 = MSB ? beef[(3-k)*8 +: 8] : beef[k*8 +: 8];
      check_output($sformatf("w2n32_put_%0d", k),  64'(e_op),   64'd1);
      check_output($sformatf("w2n32_byte_%0d", k), 64'(e_dout), 64'(word8));
      check_output($sformatf("w2n32_last_%0d", k), 64'(e_ol),   64'(k == 3));
      step_cycle();
    end
    #1;
    check_output("w2n32_idle", 64'(e_op), 64'd0);

    // 8->1: reset mid-word after 3 bits, then 0xFF must give exactly 8 ones
    a_of = 1'b1; a_ip = 1'b1; a_din = 8'h5A; a_il = 1'b0;
    step_cycle();
    a_ip = 1'b0;
    repeat (3) step_cycle();
    #1;
    check_output("rstmid_busy", 64'(a_op), 64'd1);
    reset = 1'b0;
    #1;
    check_output("rstmid_put_async",  64'(a_op),   64'd0);
    check_output("rstmid_data_async", 64'(a_dout), 64'd0);
    repeat (2) step_cycle();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_output("rstmid_no_residual", 64'(a_op), 64'd0);
      step_cycle();
    end
    a_ip = 1'b1; a_din = 8'hFF;
    step_cycle();
    a_ip = 1'b0;
    ones = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (a_op && a_dout[0]) ones++;
      step_cycle();
    end
    check_output("rstmid_ones", 64'(ones), 64'd8);
    check_output("rstmid_final_idle", 64'(a_op), 64'd0);

    // 16->16: random put/free over 1000 words
    sent = 0; recv = 0; cyc = 0;
    holding = 1'b0; prev_in = 1'b0; prev_word = '0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      if (prev_in)
        check_output("eq_latency", 64'({d_op, d_ol, d_dout}), 64'({1'b1, prev_word}));
      if (!holding) begin
        d_ip  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
        d_din = 16'($urandom);
        d_il  = 1'($urandom_range(0, 1));
      end
      d_of = 1'($urandom_range(0, 1));
      #1;
      out_x = d_op & d_of;
      in_x  = d_ip & d_if;
      if (out_x) begin
        if (q.size() == 0) begin
          check_output("eq_unexpected_word", 64'(q.size()), 64'd1);
        end else begin
          front = q.pop_front();
          check_output("eq_order", 64'({d_ol, d_dout}), 64'(front));
          recv++;
        end
      end
      if (in_x) begin
        q.push_back({d_il, d_din});
        sent++;
      end
      holding   = d_ip & !in_x;
      prev_in   = in_x;
      prev_word = {d_il, d_din};
      cyc++;
      step_cycle();
    end
    d_ip = 1'b0;
    if (cyc >= 20000) check_output("eq_timeout", 64'(cyc), 64'd0);
    check_output("eq_received", 64'(recv), 64'd1000);
    check_output("eq_count", 64'(d_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
